// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: operand forwarding, hazard stall,
// PC redirect with hold across downstream holds, saturating statistics.
module branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic [3:0]  br_op,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_addr,
  input  logic        ex_ready,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_wr_addr,
  input  logic        mem_ready,
  input  logic        id_hold,
  input  logic        judge_res,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic        bubble,
  output logic        redirect,
  output logic [15:0] br_count,
  output logic [15:0] taken_count,
  output logic [15:0] stall_count
);

  localparam logic [3:0] OP_EQ  = 4'h1;
  localparam logic [3:0] OP_NE  = 4'h2;
  localparam logic [3:0] OP_GTZ = 4'h3;
  localparam logic [3:0] OP_LEZ = 4'h4;
  localparam logic [3:0] OP_GEZ = 4'h5;
  localparam logic [3:0] OP_LTZ = 4'h6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        taken_q, taken_d;
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] tk_cnt_q, tk_cnt_d;
  logic [15:0] st_cnt_q, st_cnt_d;

  logic        op_ok, uses_rt, valid;
  logic [2:0]  chk_a, chk_b;
  logic        hazard, resolve;
  logic        stall_c, bubble_c, redirect_c;

  // {hazard, sel}: EX match shadows MEM; $0 never forwards
  function automatic logic [2:0] chk(
    input logic [4:0] r,
    input logic       used,
    input logic       exw,
    input logic [4:0] exa,
    input logic       exr,
    input logic       mw,
    input logic [4:0] ma,
    input logic       mr
  );
    logic [2:0] res;
    res = 3'b000;
    if (used && r != 5'd0) begin
      if (exw && exa == r)
        res = exr ? 3'b001 : 3'b100;
      else if (mw && ma == r)
        res = mr ? 3'b010 : 3'b100;
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // operand decode and forwarding selection
  always_comb begin
    op_ok   = (br_op == OP_EQ)  || (br_op == OP_NE)  ||
              (br_op == OP_GTZ) || (br_op == OP_LEZ) ||
              (br_op == OP_GEZ) || (br_op == OP_LTZ);
    uses_rt = (br_op == OP_EQ) || (br_op == OP_NE);
    valid   = br_valid && op_ok;
    chk_a   = chk(rs_addr, valid, ex_wr_en, ex_wr_addr,
                  ex_ready, mem_wr_en, mem_wr_addr, mem_ready);
    chk_b   = chk(rt_addr, valid && uses_rt, ex_wr_en,
                  ex_wr_addr, ex_ready, mem_wr_en,
                  mem_wr_addr, mem_ready);
    hazard  = chk_a[2] || chk_b[2];
  end

  // next-state, control outputs and counter updates
  always_comb begin
    state_d    = state_q;
    taken_d    = taken_q;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    redirect_c = 1'b0;
    resolve    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid && hazard) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = S_WAIT;
        end else if (valid) begin
          resolve = 1'b1;
        end
      end
      S_WAIT: begin
        if (!valid) begin
          state_d = S_IDLE;
        end else if (hazard) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else begin
          resolve = 1'b1;
        end
      end
      S_DONE: begin
        redirect_c = taken_q;
        if (!id_hold)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (resolve) begin
      redirect_c = judge_res;
      if (id_hold) begin
        taken_d = judge_res;
        state_d = S_DONE;
      end else begin
        state_d = S_IDLE;
      end
    end
    br_cnt_d = resolve ? sat_inc(br_cnt_q) : br_cnt_q;
    tk_cnt_d = (resolve && judge_res) ?
               sat_inc(tk_cnt_q) : tk_cnt_q;
    st_cnt_d = stall_c ? sat_inc(st_cnt_q) : st_cnt_q;
  end

  // state and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      taken_q  <= 1'b0;
      br_cnt_q <= 16'd0;
      tk_cnt_q <= 16'd0;
      st_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      taken_q  <= taken_d;
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  // outputs forced low while reset is asserted
  always_comb begin
    fwd_a_sel   = rst_n ? chk_a[1:0] : 2'b00;
    fwd_b_sel   = rst_n ? chk_b[1:0] : 2'b00;
    stall       = rst_n && stall_c;
    bubble      = rst_n && bubble_c;
    redirect    = rst_n && redirect_c;
    br_count    = br_cnt_q;
    taken_count = tk_cnt_q;
    stall_count = st_cnt_q;
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized
// cycles against a behavioural model of the branch sequencing.
module tb_branch_ctrl;

  localparam logic [3:0] OP_EQ  = 4'h1;
  localparam logic [3:0] OP_NE  = 4'h2;
  localparam logic [3:0] OP_GTZ = 4'h3;
  localparam logic [3:0] OP_LEZ = 4'h4;
  localparam logic [3:0] OP_GEZ = 4'h5;
  localparam logic [3:0] OP_LTZ = 4'h6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic [3:0]  br_op;
  logic [4:0]  rs_addr, rt_addr;
  logic        ex_wr_en, ex_ready;
  logic [4:0]  ex_wr_addr;
  logic        mem_wr_en, mem_ready;
  logic [4:0]  mem_wr_addr;
  logic        id_hold, judge_res;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, bubble, redirect;
  logic [15:0] br_count, taken_count, stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 free, 1 waiting on operand, 2 redirect held
  int m_mode;
  bit m_taken;
  int m_br, m_tk, m_st;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid),
    .br_op(br_op), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .ex_ready(ex_ready), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_ready(mem_ready),
    .id_hold(id_hold), .judge_res(judge_res),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .bubble(bubble), .redirect(redirect),
    .br_count(br_count), .taken_count(taken_count),
    .stall_count(stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid = 0; br_op = OP_EQ;
    rs_addr = 0; rt_addr = 0;
    ex_wr_en = 0; ex_wr_addr = 0; ex_ready = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_ready = 0;
    id_hold = 0; judge_res = 0;
  endtask

  // where a source register's value comes from, per producer priority
  function automatic void src(input logic [4:0] r,
                              input bit used,
                              output logic [1:0] sel,
                              output bit hz);
    sel = 2'd0; hz = 0;
    if (!used || r == 0) return;
    if (ex_wr_en && ex_wr_addr == r) begin
      if (ex_ready) sel = 2'd1; else hz = 1;
    end else if (mem_wr_en && mem_wr_addr == r) begin
      if (mem_ready) sel = 2'd2; else hz = 1;
    end
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    br_valid = 1; rs_addr = 3; judge_res = 1;
    #2;
    n_tests++;
    if ({stall, bubble, redirect, fwd_a_sel} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 00000",
               {stall, bubble, redirect, fwd_a_sel});
    end
    n_tests++;
    if ({br_count, taken_count, stall_count} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h %h %h want 0",
               br_count, taken_count, stall_count);
    end
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_beq();
    br_valid = 1; br_op = OP_EQ; rs_addr = 3; rt_addr = 4;
    judge_res = 1;
    #1;
    n_tests++;
    if ({fwd_a_sel, fwd_b_sel, stall, redirect} !== 6'b000001) begin
      n_fail++;
      $display("FAIL beq_outs got %b want 000001",
               {fwd_a_sel, fwd_b_sel, stall, redirect});
    end
    tick();
    idle_inputs();
    n_tests++;
    if (br_count !== 16'd1 || taken_count !== 16'd1) begin
      n_fail++;
      $display("FAIL beq_cnt got %0d %0d want 1 1",
               br_count, taken_count);
    end
  endtask

  task automatic test_load_use();
    br_valid = 1; br_op = OP_GTZ; rs_addr = 5; rt_addr = 7;
    ex_wr_en = 1; ex_wr_addr = 5; ex_ready = 0;
    #1;
    n_tests++;
    if ({stall, bubble, redirect} !== 3'b110) begin
      n_fail++;
      $display("FAIL lu_ex got %b want 110",
               {stall, bubble, redirect});
    end
    tick();
    ex_wr_en = 0;
    mem_wr_en = 1; mem_wr_addr = 5; mem_ready = 0;
    #1;
    n_tests++;
    if ({stall, bubble, redirect} !== 3'b110) begin
      n_fail++;
      $display("FAIL lu_mem got %b want 110",
               {stall, bubble, redirect});
    end
    tick();
    mem_wr_en = 0;
    ex_wr_en = 1; ex_wr_addr = 7; ex_ready = 0;
    judge_res = 0;
    #1;
    n_tests++;
    if ({stall, bubble, fwd_a_sel, fwd_b_sel, redirect} !== 7'b0) begin
      n_fail++;
      $display("FAIL lu_res got %b want 0000000",
               {stall, bubble, fwd_a_sel, fwd_b_sel, redirect});
    end
    tick();
    idle_inputs();
    n_tests++;
    if (stall_count !== 16'd2 || br_count !== 16'd2 ||
        taken_count !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_cnt got st=%0d br=%0d tk=%0d want 2 2 1",
               stall_count, br_count, taken_count);
    end
  endtask

  task automatic test_ex_precedence();
    br_valid = 1; br_op = OP_NE; rs_addr = 6; rt_addr = 0;
    ex_wr_en = 1; ex_wr_addr = 6; ex_ready = 1;
    mem_wr_en = 1; mem_wr_addr = 6; mem_ready = 0;
    judge_res = 1;
    #1;
    n_tests++;
    if ({fwd_a_sel, fwd_b_sel, stall, redirect} !== 6'b010001) begin
      n_fail++;
      $display("FAIL exprec got %b want 010001",
               {fwd_a_sel, fwd_b_sel, stall, redirect});
    end
    tick();
    br_op = OP_EQ; rs_addr = 0;
    ex_wr_addr = 0; ex_ready = 0; mem_wr_en = 0;
    judge_res = 0;
    #1;
    n_tests++;
    if ({fwd_a_sel, stall, redirect} !== 4'b0) begin
      n_fail++;
      $display("FAIL r0 got %b want 0000",
               {fwd_a_sel, stall, redirect});
    end
    tick();
    idle_inputs();
    n_tests++;
    if (br_count !== 16'd4 || taken_count !== 16'd2) begin
      n_fail++;
      $display("FAIL exprec_cnt got %0d %0d want 4 2",
               br_count, taken_count);
    end
  endtask

  task automatic test_hold();
    br_valid = 1; br_op = OP_EQ; rs_addr = 1; rt_addr = 2;
    judge_res = 1; id_hold = 1;
    #1;
    n_tests++;
    if (redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_c0 got %b want 1", redirect);
    end
    tick();
    judge_res = 0;
    for (int i = 1; i <= 3; i++) begin
      id_hold = (i < 3);
      #1;
      n_tests++;
      if ({redirect, stall} !== 2'b10) begin
        n_fail++;
        $display("FAIL hold_c%0d got %b want 10",
                 i, {redirect, stall});
      end
      tick();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (redirect !== 1'b0 || br_count !== 16'd5 ||
        taken_count !== 16'd3) begin
      n_fail++;
      $display("FAIL hold_end got r=%b br=%0d tk=%0d want 0 5 3",
               redirect, br_count, taken_count);
    end
  endtask

  task automatic test_reset_wait();
    br_valid = 1; br_op = OP_EQ; rs_addr = 9; rt_addr = 0;
    ex_wr_en = 1; ex_wr_addr = 9; ex_ready = 0;
    judge_res = 1;
    tick();
    rst_n = 0;
    #1;
    n_tests++;
    if ({stall, bubble, redirect} !== 3'b0 ||
        br_count !== 16'd0 || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstwait got %b br=%0d st=%0d want 000 0 0",
               {stall, bubble, redirect}, br_count, stall_count);
    end
    idle_inputs();
    judge_res = 1;
    tick();
    rst_n = 1;
    tick();
    n_tests++;
    if (redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_redir got %b want 0", redirect);
    end
    idle_inputs();
  endtask

  task automatic test_invalid_op();
    br_valid = 1; br_op = 4'hF; rs_addr = 1; rt_addr = 2;
    ex_wr_en = 1; ex_wr_addr = 1; ex_ready = 0;
    mem_wr_en = 1; mem_wr_addr = 2; mem_ready = 1;
    judge_res = 1;
    #1;
    n_tests++;
    if ({stall, bubble, redirect, fwd_a_sel, fwd_b_sel} !== 7'b0) begin
      n_fail++;
      $display("FAIL inv_outs got %b want 0000000",
               {stall, bubble, redirect, fwd_a_sel, fwd_b_sel});
    end
    tick();
    idle_inputs();
    n_tests++;
    if ({br_count, taken_count, stall_count} !== 48'd0) begin
      n_fail++;
      $display("FAIL inv_cnt got %0d %0d %0d want 0 0 0",
               br_count, taken_count, stall_count);
    end
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    bit ha, hb, vld, haz, res;
    bit es, eb_b, er;
    m_mode = 0; m_taken = 0; m_br = 0; m_tk = 0; m_st = 0;
    for (int c = 0; c < 3000; c++) begin
      br_valid    = ($urandom_range(3) != 0);
      br_op       = 4'($urandom_range(7));
      rs_addr     = 5'($urandom_range(3));
      rt_addr     = 5'($urandom_range(3));
      ex_wr_en    = 1'($urandom);
      ex_wr_addr  = 5'($urandom_range(3));
      ex_ready    = 1'($urandom);
      mem_wr_en   = 1'($urandom);
      mem_wr_addr = 5'($urandom_range(3));
      mem_ready   = 1'($urandom);
      id_hold     = ($urandom_range(3) == 0);
      judge_res   = 1'($urandom);
      #1;
      vld = br_valid && br_op inside
            {OP_EQ, OP_NE, OP_GTZ, OP_LEZ, OP_GEZ, OP_LTZ};
      src(rs_addr, vld, ea, ha);
      src(rt_addr, vld && br_op inside {OP_EQ, OP_NE}, eb, hb);
      haz = ha || hb;
      es = 0; er = 0; res = 0;
      if (m_mode == 2) er = m_taken;
      else if (vld && haz) es = 1;
      else if (vld) begin res = 1; er = judge_res; end
      eb_b = es;
      n_tests++;
      if ({stall, bubble, redirect, fwd_a_sel, fwd_b_sel} !==
          {es, eb_b, er, ea, eb}) begin
        n_fail++;
        $display("FAIL rnd_out c=%0d got %b want %b", c,
                 {stall, bubble, redirect, fwd_a_sel, fwd_b_sel},
                 {es, eb_b, er, ea, eb});
      end
      if (m_mode == 2) begin
        if (!id_hold) m_mode = 0;
      end else if (es) begin
        m_mode = 1;
        m_st = (m_st < 65535) ? m_st + 1 : m_st;
      end else if (res) begin
        m_br = (m_br < 65535) ? m_br + 1 : m_br;
        if (judge_res) m_tk = (m_tk < 65535) ? m_tk + 1 : m_tk;
        m_taken = judge_res;
        m_mode = id_hold ? 2 : 0;
      end else begin
        m_mode = 0;
      end
      tick();
      n_tests++;
      if (br_count !== 16'(m_br) || taken_count !== 16'(m_tk) ||
          stall_count !== 16'(m_st)) begin
        n_fail++;
        $display("FAIL rnd_cnt c=%0d got %0d %0d %0d want %0d %0d %0d",
                 c, br_count, taken_count, stall_count,
                 m_br, m_tk, m_st);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    br_valid = 1; br_op = OP_EQ; rs_addr = 1;
    ex_wr_en = 1; ex_wr_addr = 1; ex_ready = 0;
    repeat (65538) tick();
    n_tests++;
    if (stall_count !== 16'hFFFF || br_count !== 16'd0) begin
      n_fail++;
      $display("FAIL sat got st=%h br=%0d want ffff 0",
               stall_count, br_count);
    end
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_stall got %b want 1", stall);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_load_use();
    test_ex_precedence();
    test_hold();
    test_reset_wait();
    test_invalid_op();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
